// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared types and control-word field offsets for the decode-stage
// hazard controller.
package decode_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    MEM_WAIT
  } ctrl_state_t;

  localparam int CW_RD_HI  = 25;
  localparam int CW_RD_LO  = 21;
  localparam int CW_RS2_HI = 20;
  localparam int CW_RS2_LO = 16;
  localparam int CW_RS1_HI = 15;
  localparam int CW_RS1_LO = 11;
  localparam int CW_WE     = 6;
  localparam int CW_LOAD   = 4;

  localparam int REG_COUNT = 32;
  localparam int REG_AW    = $clog2(REG_COUNT);

  typedef logic [REG_AW-1:0]    reg_addr_t;
  typedef logic [REG_COUNT-1:0] reg_mask_t;

  function automatic reg_mask_t reg_onehot(
    input reg_addr_t a,
    input logic      en
  );
    reg_mask_t m;
    m = en ? (reg_mask_t'(1) << a) : '0;
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decode/MEM/WB sideband bundle between the pipeline and the hazard
// controller.
interface decode_hazard_ctrl_if;
  import decode_ctrl_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs1;
  reg_addr_t id_rs2;
  logic      id_use_rs1;
  logic      id_use_rs2;
  logic      id_we;
  reg_addr_t id_rd;
  logic      id_load;
  logic      ex_branch_taken;
  logic      dmem_req;
  logic      dmem_ready;
  logic      wb_we;
  reg_addr_t wb_rd;

  logic      buble;
  logic      pc_stall;
  logic      ifid_stall;
  logic      ifid_flush;
  logic      exmem_stall;
  logic      mem_timeout;
  reg_mask_t pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output id_we, id_rd, id_load, ex_branch_taken,
    output dmem_req, dmem_ready, wb_we, wb_rd,
    input  buble, pc_stall, ifid_stall, ifid_flush,
    input  exmem_stall, mem_timeout, pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  id_we, id_rd, id_load, ex_branch_taken,
    input  dmem_req, dmem_ready, wb_we, wb_rd,
    output buble, pc_stall, ifid_stall, ifid_flush,
    output exmem_stall, mem_timeout, pending
  );

endinterface

// File: rtl/decode_hazard_ctrl_scoreboard.sv
// In-flight writer bitmap: one set port, one clear port, two read ports.
// x0 is never marked pending.
module reg_scoreboard
  import decode_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      set_en,
  input  reg_addr_t set_addr,
  input  logic      clr_en,
  input  reg_addr_t clr_addr,
  input  reg_addr_t rd_addr_a,
  input  reg_addr_t rd_addr_b,
  output logic      rd_a,
  output logic      rd_b,
  output reg_mask_t pending
);

  reg_mask_t pending_q;
  reg_mask_t pending_d;

  // set is OR-ed after the clear so a same-cycle re-issue wins
  always_comb begin
    pending_d = pending_q & ~reg_onehot(clr_addr, clr_en);
    pending_d = pending_d | reg_onehot(set_addr, set_en);
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign rd_a    = pending_q[rd_addr_a];
  assign rd_b    = pending_q[rd_addr_b];
  assign pending = pending_q;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage sequencer: RAW stalls, dmem freezes, branch flushes.
// Define FORWARDING_EN to track only load destinations in the scoreboard.
module decode_hazard_ctrl
  import decode_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input logic clk,
  input logic reset,
  decode_hazard_ctrl_if.slave bus
);

  localparam int FL_LOAD_I = (FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0;
  localparam logic [2:0]  FL_LOAD = 3'(FL_LOAD_I);
  localparam logic [15:0] TMO     = 16'(MEM_TIMEOUT);

  ctrl_state_t state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic      freeze, flushing, hazard, buble, issue;
  logic      hit_a, hit_b, set_sel, set_en;
  reg_mask_t pending_w;

  assign freeze   = bus.dmem_req & ~bus.dmem_ready;
  assign flushing = ~freeze &
                    (bus.ex_branch_taken | (state_q == FLUSH));
  assign hazard   = ~freeze & ~flushing & bus.id_valid &
                    ((bus.id_use_rs1 & hit_a) |
                     (bus.id_use_rs2 & hit_b));
  assign buble    = reset | flushing | hazard;
  assign issue    = ~reset & bus.id_valid & ~buble & ~freeze;

`ifdef FORWARDING_EN
  assign set_sel = bus.id_we & bus.id_load;
`else
  assign set_sel = bus.id_we | bus.id_load;
`endif

  assign set_en = issue & set_sel & (bus.id_rd != '0);

  reg_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (set_en),
    .set_addr  (bus.id_rd),
    .clr_en    (bus.wb_we),
    .clr_addr  (bus.wb_rd),
    .rd_addr_a (bus.id_rs1),
    .rd_addr_b (bus.id_rs2),
    .rd_a      (hit_a),
    .rd_b      (hit_b),
    .pending   (pending_w)
  );

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (freeze) begin
      // FLUSH holds its counter across a freeze
      wait_cnt_d = (wait_cnt_q >= TMO) ? wait_cnt_q
                                       : wait_cnt_q + 16'd1;
      if (wait_cnt_d == TMO) mem_timeout_d = 1'b1;
      if (state_q == RUN) state_d = MEM_WAIT;
    end else if (bus.ex_branch_taken) begin
      if (FLUSH_CYCLES > 1) begin
        state_d     = FLUSH;
        flush_cnt_d = FL_LOAD;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == FLUSH) begin
      if (flush_cnt_q == '0) state_d = RUN;
      else flush_cnt_d = flush_cnt_q - 3'd1;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign bus.buble       = buble;
  assign bus.pc_stall    = ~reset & (freeze | hazard);
  assign bus.ifid_stall  = ~reset & (freeze | hazard);
  assign bus.ifid_flush  = ~reset & flushing;
  assign bus.exmem_stall = ~reset & freeze;
  assign bus.mem_timeout = ~reset & mem_timeout_q;
  assign bus.pending     = reset ? '0 : pending_w;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=3.
// Output order in outs: {buble, pc_stall, ifid_stall, ifid_flush, exmem_stall}.
module tb_decode_hazard_ctrl;
  import decode_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  decode_hazard_ctrl_if bus();

  decode_hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .MEM_TIMEOUT  (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [4:0] outs;
  assign outs = {bus.buble, bus.pc_stall, bus.ifid_stall,
                 bus.ifid_flush, bus.exmem_stall};

  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_RST   = 5'b10000;
  localparam logic [4:0] O_HAZ   = 5'b11100;
  localparam logic [4:0] O_FLUSH = 5'b10010;
  localparam logic [4:0] O_FRZ   = 5'b01101;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid        = 1'b0;
    bus.id_rs1          = '0;
    bus.id_rs2          = '0;
    bus.id_use_rs1      = 1'b0;
    bus.id_use_rs2      = 1'b0;
    bus.id_we           = 1'b0;
    bus.id_rd           = '0;
    bus.id_load         = 1'b0;
    bus.ex_branch_taken = 1'b0;
    bus.dmem_req        = 1'b0;
    bus.dmem_ready      = 1'b0;
    bus.wb_we           = 1'b0;
    bus.wb_rd           = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic instr(input logic [4:0] rd, input logic we,
                       input logic ld, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    bus.id_valid   = 1'b1;
    bus.id_rd      = rd;
    bus.id_we      = we;
    bus.id_load    = ld;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_use_rs1 = 1'b1;
    bus.id_use_rs2 = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    #1;
    checks++;
    if (outs !== O_RST) begin
      errors++;
      $display("FAIL reset_outs got=%b exp=%b", outs, O_RST);
    end
    checks++;
    if (bus.pending !== 32'h0 || bus.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state pending=%h tmo=%b exp 0/0",
               bus.pending, bus.mem_timeout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL post_reset_outs got=%b exp=%b", outs, O_IDLE);
    end
  endtask

  task automatic test_load_use();
    logic exp6;
    do_reset();
    instr(5'd5, 1'b1, 1'b1, 5'd2, 5'd3);
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL lw_issue got=%b exp=%b", outs, O_IDLE);
    end
    tick();
    instr(5'd6, 1'b1, 1'b0, 5'd5, 5'd1);
    for (int i = 0; i < 3; i++) begin
      bus.wb_we = (i == 2);
      bus.wb_rd = 5'd5;
      #1;
      checks++;
      if (outs !== O_HAZ || bus.pending[5] !== 1'b1) begin
        errors++;
        $display("FAIL load_use_stall%0d got=%b p5=%b exp=%b p5=1",
                 i, outs, bus.pending[5], O_HAZ);
      end
      tick();
    end
    bus.wb_we = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL load_use_release got=%b exp=%b", outs, O_IDLE);
    end
    tick();
    idle();
    #1;
`ifdef FORWARDING_EN
    exp6 = 1'b0;
`else
    exp6 = 1'b1;
`endif
    checks++;
    if (bus.pending[5] !== 1'b0 || bus.pending[6] !== exp6) begin
      errors++;
      $display("FAIL load_use_sb p5=%b p6=%b exp p5=0 p6=%b",
               bus.pending[5], bus.pending[6], exp6);
    end
  endtask

  task automatic test_alu_raw();
    do_reset();
    instr(5'd7, 1'b1, 1'b0, 5'd1, 5'd2);
    tick();
    instr(5'd8, 1'b1, 1'b0, 5'd7, 5'd2);
    #1;
`ifdef FORWARDING_EN
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL alu_raw_fwd got=%b exp=%b", outs, O_IDLE);
    end
`else
    checks++;
    if (outs !== O_HAZ) begin
      errors++;
      $display("FAIL alu_raw_stall0 got=%b exp=%b", outs, O_HAZ);
    end
    tick();
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd7;
    #1;
    checks++;
    if (outs !== O_HAZ) begin
      errors++;
      $display("FAIL alu_raw_stall1 got=%b exp=%b", outs, O_HAZ);
    end
    tick();
    bus.wb_we = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL alu_raw_release got=%b exp=%b", outs, O_IDLE);
    end
`endif
    tick();
    idle();
  endtask

  task automatic test_x0();
    do_reset();
    instr(5'd0, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    instr(5'd4, 1'b1, 1'b0, 5'd0, 5'd0);
    #1;
    checks++;
    if (outs !== O_IDLE || bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL x0_read got=%b pend=%h exp=%b pend=0",
               outs, bus.pending, O_IDLE);
    end
    tick();
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    bus.ex_branch_taken = 1'b1;
    instr(5'd3, 1'b1, 1'b1, 5'd1, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_FLUSH) begin
        errors++;
        $display("FAIL branch_flush%0d got=%b exp=%b", i, outs, O_FLUSH);
      end
      tick();
      bus.ex_branch_taken = 1'b0;
    end
    #1;
    checks++;
    if (outs !== O_IDLE || bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL branch_end got=%b pend=%h exp=%b pend=0",
               outs, bus.pending, O_IDLE);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.ex_branch_taken = (i < 2);
      exp = (i < 4) ? O_FLUSH : O_IDLE;
      #1;
      checks++;
      if (outs !== exp) begin
        errors++;
        $display("FAIL b2b_branch%0d got=%b exp=%b", i, outs, exp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mem_wait();
    logic tmo;
    do_reset();
    bus.dmem_req = 1'b1;
    instr(5'd9, 1'b1, 1'b1, 5'd1, 5'd2);
    for (int i = 0; i < 4; i++) begin
      tmo = (i >= 3);
      #1;
      checks++;
      if (outs !== O_FRZ || bus.mem_timeout !== tmo) begin
        errors++;
        $display("FAIL mem_wait%0d got=%b tmo=%b exp=%b tmo=%b",
                 i, outs, bus.mem_timeout, O_FRZ, tmo);
      end
      tick();
    end
    checks++;
    if (bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL mem_wait_noissue pend=%h exp=0", bus.pending);
    end
    bus.dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_IDLE || bus.mem_timeout !== 1'b1) begin
      errors++;
      $display("FAIL mem_ready got=%b tmo=%b exp=%b tmo=1",
               outs, bus.mem_timeout, O_IDLE);
    end
    tick();
    idle();
    tick();
    checks++;
    if (bus.mem_timeout !== 1'b1 || bus.pending[9] !== 1'b1) begin
      errors++;
      $display("FAIL mem_sticky tmo=%b p9=%b exp 1/1",
               bus.mem_timeout, bus.pending[9]);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] seq_exp [5];
    logic [4:0] seq_frz;
    do_reset();
    instr(5'd9, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    bus.wb_we = 1'b1;
    bus.wb_rd = 5'd9;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++;
      $display("FAIL reissue_x9 got=%b exp=%b", outs, O_IDLE);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.pending[9] !== 1'b1) begin
      errors++;
      $display("FAIL set_wins p9=%b exp=1", bus.pending[9]);
    end
    // branch under freeze, then a freeze inside FLUSH
    seq_exp[0] = O_FRZ;
    seq_exp[1] = O_FLUSH;
    seq_exp[2] = O_FRZ;
    seq_exp[3] = O_FLUSH;
    seq_exp[4] = O_FLUSH;
    seq_frz = 5'b00101;
    for (int i = 0; i < 5; i++) begin
      bus.ex_branch_taken = (i < 2);
      bus.dmem_req   = seq_frz[i];
      bus.dmem_ready = 1'b0;
      #1;
      checks++;
      if (outs !== seq_exp[i]) begin
        errors++;
        $display("FAIL frz_branch%0d got=%b exp=%b",
                 i, outs, seq_exp[i]);
      end
      tick();
    end
    idle();
    #1;
    checks++;
    if (outs !== O_IDLE || bus.mem_timeout !== 1'b0) begin
      errors++;
      $display("FAIL frz_branch_end got=%b tmo=%b exp=%b tmo=0",
               outs, bus.mem_timeout, O_IDLE);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    instr(5'd4, 1'b1, 1'b1, 5'd1, 5'd2);
    tick();
    idle();
    bus.ex_branch_taken = 1'b1;
    tick();
    bus.ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (outs !== O_FLUSH || bus.pending[4] !== 1'b1) begin
      errors++;
      $display("FAIL mid_flush got=%b p4=%b exp=%b p4=1",
               outs, bus.pending[4], O_FLUSH);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== O_RST || bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL rst_hold got=%b pend=%h exp=%b pend=0",
               outs, bus.pending, O_RST);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (outs !== O_IDLE || bus.pending !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid_flush got=%b pend=%h exp=%b pend=0",
               outs, bus.pending, O_IDLE);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_alu_raw();
    test_x0();
    test_branch();
    test_back_to_back();
    test_mem_wait();
    test_simultaneous();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
